// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the multi-cycle RV32I control path: major opcodes,
//   FSM state encoding, and the ImmGen / ALU-source / write-back select
//   encodings. ImmGen and the datapath muxes decode the same values.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        SRCA_RS1   = 2'd0,
        SRCA_PC    = 2'd1,
        SRCA_OLDPC = 2'd2
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_FUNCT = 2'd1
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MEM    = 2'd1,
        WB_PC     = 2'd2,
        WB_IMM    = 2'd3
    } wb_sel_e;

    // One-hot instruction class; all zero for an illegal opcode.
    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic opimm;
        logic op;
        logic lui;
        logic auipc;
    } op_class_t;

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// riscv_multicycle_ctrl_if
//   Unified memory-port handshake between the control FSM and memory.
//   mem_req      request, held until mem_ready
//   mem_we       1 = store, stable while mem_req
//   mem_addr_sel 0 = PC, 1 = ALUOut
//   mem_ready    memory completes the current request this cycle
interface riscv_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/riscv_ctrl_decode.sv
// riscv_ctrl_decode
//   Combinational opcode classifier.
//   opcode_i   7  instruction opcode
//   class_o    9  one-hot instruction class
//   imm_sel_o  3  ImmGen format for this opcode
//   legal_o    1  opcode is one of the supported RV32I major opcodes
module riscv_ctrl_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_t  class_o,
    output imm_sel_e   imm_sel_o,
    output logic       legal_o
);

    always_comb begin
        class_o   = '0;
        imm_sel_o = IMM_I;
        legal_o   = 1'b1;
        case (opcode_i)
            OPC_LOAD:   class_o.load = 1'b1;
            OPC_STORE: begin
                class_o.store = 1'b1;
                imm_sel_o     = IMM_S;
            end
            OPC_BRANCH: begin
                class_o.branch = 1'b1;
                imm_sel_o      = IMM_B;
            end
            OPC_JAL: begin
                class_o.jal = 1'b1;
                imm_sel_o   = IMM_J;
            end
            OPC_JALR:   class_o.jalr  = 1'b1;
            OPC_OPIMM:  class_o.opimm = 1'b1;
            OPC_OP:     class_o.op    = 1'b1;
            OPC_LUI: begin
                class_o.lui = 1'b1;
                imm_sel_o   = IMM_U;
            end
            OPC_AUIPC: begin
                class_o.auipc = 1'b1;
                imm_sel_o     = IMM_U;
            end
            default:    legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
//   Main control FSM of the multi-cycle RV32I core. Sequences the shared ALU,
//   unified memory port, ImmGen and register file through
//   FETCH / DECODE / EXEC / MEM / WB, with a sticky TRAP for illegal opcodes.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 when memory is ready
//   DECODE | latch opcode, ALUOut <= OldPC + imm (branch/JAL target)
//   EXEC   | ALU operation / address calc / branch or jump PC update
//   MEM    | data load or store at ALUOut
//   WB     | register-file write
//   TRAP   | illegal opcode seen; only reset leaves
//
// Ports
//   clk_i, rst_ni          clock / async active-low reset
//   Opcode_i               IR[6:0], valid from DECODE onward
//   BranchTaken_i          branch comparator result, valid in EXEC
//   mem                    memory handshake (master side)
//   IRWrite_o, PCWrite_o   IR/OldPC and PC load strobes
//   PCSel_o                0 = ALU result, 1 = ALUOut
//   ImmSel_o               ImmGen format
//   ALUSrcA_o/ALUSrcB_o    ALU operand selects; ALUOp_o add or funct-decoded
//   RegWrite_o, WbSel_o    register write strobe and source
//   Illegal_o              sticky illegal-opcode flag
//   State_o                current state (debug)
module riscv_multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter bit RESET_TRAP_EN = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [6:0]                     Opcode_i,
    input  logic                           BranchTaken_i,
    riscv_multicycle_ctrl_if.master        mem,
    output logic                           IRWrite_o,
    output logic                           PCWrite_o,
    output logic                           PCSel_o,
    output logic [2:0]                     ImmSel_o,
    output logic [1:0]                     ALUSrcA_o,
    output logic [1:0]                     ALUSrcB_o,
    output logic [1:0]                     ALUOp_o,
    output logic                           RegWrite_o,
    output logic [1:0]                     WbSel_o,
    output logic                           Illegal_o,
    output logic [2:0]                     State_o
);

    state_e     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic       illegal_q, illegal_d;

    // In DECODE the opcode register is still being loaded, so decode the
    // live IR opcode there; later states use the latched copy.
    logic [6:0] dec_opcode;
    op_class_t  dec_class;
    imm_sel_e   dec_imm_sel;
    logic       dec_legal;

    assign dec_opcode = (state_q == ST_DECODE) ? Opcode_i : op_q;

    riscv_ctrl_decode u_decode (
        .opcode_i  (dec_opcode),
        .class_o   (dec_class),
        .imm_sel_o (dec_imm_sel),
        .legal_o   (dec_legal)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem.mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!dec_legal)         state_d = RESET_TRAP_EN ? ST_TRAP : ST_FETCH;
                else if (dec_class.lui) state_d = ST_WB;
                else                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_class.load || dec_class.store) state_d = ST_MEM;
                else if (dec_class.branch)             state_d = ST_FETCH;
                else                                   state_d = ST_WB;
            end
            ST_MEM: begin
                if (mem.mem_ready) state_d = dec_class.load ? ST_WB : ST_FETCH;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    assign op_d      = (state_q == ST_DECODE) ? Opcode_i : op_q;
    assign illegal_d = illegal_q | (state_d == ST_TRAP);

    imm_sel_e   imm_sel;
    alu_src_a_e alu_a;
    alu_src_b_e alu_b;
    alu_op_e    alu_op;
    wb_sel_e    wb_sel;
    logic       mem_req, mem_we, mem_addr_sel;
    logic       ir_write, pc_write, pc_sel, reg_write;

    // Outputs are forced low while rst_ni is asserted so an in-flight memory
    // request is abandoned in the same instant, without waiting for a clock.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        reg_write    = 1'b0;
        imm_sel      = IMM_I;
        alu_a        = SRCA_RS1;
        alu_b        = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        wb_sel       = WB_ALUOUT;
        if (rst_ni) begin
            if (state_q != ST_FETCH && state_q != ST_TRAP) imm_sel = dec_imm_sel;
            case (state_q)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    alu_a    = SRCA_PC;
                    alu_b    = SRCB_FOUR;
                    ir_write = mem.mem_ready;
                    pc_write = mem.mem_ready;
                end
                ST_DECODE: begin
                    alu_a = SRCA_OLDPC;
                    alu_b = SRCB_IMM;
                end
                ST_EXEC: begin
                    if (dec_class.op) begin
                        alu_op = ALUOP_FUNCT;
                    end else if (dec_class.opimm) begin
                        alu_b  = SRCB_IMM;
                        alu_op = ALUOP_FUNCT;
                    end else if (dec_class.load || dec_class.store) begin
                        alu_b = SRCB_IMM;
                    end else if (dec_class.branch) begin
                        pc_write = BranchTaken_i;
                        pc_sel   = 1'b1;
                    end else if (dec_class.jal) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                    end else if (dec_class.jalr) begin
                        alu_b    = SRCB_IMM;
                        pc_write = 1'b1;
                    end else if (dec_class.auipc) begin
                        alu_a = SRCA_OLDPC;
                        alu_b = SRCB_IMM;
                    end
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = dec_class.store;
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    if (dec_class.load)                      wb_sel = WB_MEM;
                    else if (dec_class.jal || dec_class.jalr) wb_sel = WB_PC;
                    else if (dec_class.lui)                  wb_sel = WB_IMM;
                    else                                     wb_sel = WB_ALUOUT;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req      = mem_req;
    assign mem.mem_we       = mem_we;
    assign mem.mem_addr_sel = mem_addr_sel;
    assign IRWrite_o        = ir_write;
    assign PCWrite_o        = pc_write;
    assign PCSel_o          = pc_sel;
    assign ImmSel_o         = imm_sel;
    assign ALUSrcA_o        = alu_a;
    assign ALUSrcB_o        = alu_b;
    assign ALUOp_o          = alu_op;
    assign RegWrite_o       = reg_write;
    assign WbSel_o          = wb_sel;
    assign Illegal_o        = illegal_q;
    assign State_o          = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Testbench for riscv_multicycle_ctrl: per-cycle vector table plus
// hand-written multi-cycle sequences (wait states, trap, reset mid-request).
module tb_riscv_multicycle_ctrl;
    import riscv_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, asel, irw, pcw, psel;
        logic [2:0] imm;
        logic [1:0] sa, sb, aop;
        logic       rgw;
        logic [1:0] wbs;
        logic       ill;
    } outs_t;

    typedef struct {
        string      name;
        logic [6:0] opc;
        logic       tk;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opc = '0;
    logic       tk = 1'b0;
    logic       irw, pcw, psel, rgw, ill;
    logic [2:0] imm, st;
    logic [1:0] sa, sb, aop, wbs;

    int total = 0;
    int bad   = 0;

    riscv_multicycle_ctrl_if mif ();

    riscv_multicycle_ctrl #(.RESET_TRAP_EN(1'b1)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .Opcode_i      (opc),
        .BranchTaken_i (tk),
        .mem           (mif),
        .IRWrite_o     (irw),
        .PCWrite_o     (pcw),
        .PCSel_o       (psel),
        .ImmSel_o      (imm),
        .ALUSrcA_o     (sa),
        .ALUSrcB_o     (sb),
        .ALUOp_o       (aop),
        .RegWrite_o    (rgw),
        .WbSel_o       (wbs),
        .Illegal_o     (ill),
        .State_o       (st)
    );

    always #5 clk = ~clk;

    function automatic outs_t o(input int s, req, we, asel, ir, pw, ps, im,
                                input int a, b, op, rw, wb, il);
        outs_t r;
        r.st = 3'(s);   r.req = 1'(req); r.we = 1'(we); r.asel = 1'(asel);
        r.irw = 1'(ir); r.pcw = 1'(pw);  r.psel = 1'(ps); r.imm = 3'(im);
        r.sa = 2'(a);   r.sb = 2'(b);    r.aop = 2'(op);  r.rgw = 1'(rw);
        r.wbs = 2'(wb); r.ill = 1'(il);
        return r;
    endfunction

    function automatic outs_t fe();                      return o(0,1,0,0,1,1,0,0,1,2,0,0,0,0); endfunction
    function automatic outs_t fw();                      return o(0,1,0,0,0,0,0,0,1,2,0,0,0,0); endfunction
    function automatic outs_t de(input int im);          return o(1,0,0,0,0,0,0,im,2,1,0,0,0,0); endfunction
    function automatic outs_t wb(input int im, input int w); return o(4,0,0,0,0,0,0,im,0,0,0,1,w,0); endfunction

    function automatic outs_t actual();
        outs_t r;
        r.st = st; r.req = mif.mem_req; r.we = mif.mem_we; r.asel = mif.mem_addr_sel;
        r.irw = irw; r.pcw = pcw; r.psel = psel; r.imm = imm;
        r.sa = sa; r.sb = sb; r.aop = aop; r.rgw = rgw; r.wbs = wbs; r.ill = ill;
        return r;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t a;
        a = actual();
        total++;
        if (a !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, a, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    vec_t vecs[$];

    task automatic add(input string n, input logic [6:0] op, input logic t,
                       input logic r, input outs_t e);
        vec_t v;
        v.name = n; v.opc = op; v.tk = t; v.rdy = r; v.exp = e;
        vecs.push_back(v);
    endtask

    // Runs one instruction from FETCH back to FETCH with fw fetch wait cycles
    // and mw data wait cycles. Entered and left just after a falling edge.
    task automatic run_instr(input logic [6:0] op, input logic t, input int fwn, input int mwn,
                             output int cyc, output int irw_n, output int rgw_n,
                             output int we_n, output int strobe_err, output int wbs_seen);
        int  fwc;
        int  mwc;
        bit  left;
        fwc = 0; mwc = 0; left = 0;
        cyc = 0; irw_n = 0; rgw_n = 0; we_n = 0; strobe_err = 0; wbs_seen = -1;
        for (int k = 0; k < 60; k++) begin
            opc = op;
            tk  = t;
            if (st == 3'd0) begin
                mif.mem_ready = (fwc >= fwn);
                if (fwc < fwn) fwc++;
            end else if (st == 3'd3) begin
                mif.mem_ready = (mwc >= mwn);
                if (mwc < mwn) mwc++;
            end else begin
                mif.mem_ready = 1'b1;
            end
            #1;
            if (irw) irw_n++;
            if (rgw) begin
                rgw_n++;
                wbs_seen = int'(wbs);
            end
            if (mif.mem_we) we_n++;
            if ((mif.mem_we || mif.mem_addr_sel) && st != 3'd3) strobe_err++;
            if (st != 3'd0) left = 1;
            @(negedge clk);
            cyc++;
            if (left && st == 3'd0) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, irw_n, rgw_n, we_n, serr, wsel;

        add("addi F wait", OPC_OPIMM, 0, 0, fw());
        add("addi F wait2", OPC_OPIMM, 0, 0, fw());
        add("addi F",   OPC_OPIMM, 0, 1, fe());
        add("addi D",   OPC_OPIMM, 0, 1, de(0));
        add("addi E",   OPC_OPIMM, 0, 1, o(2,0,0,0,0,0,0,0,0,1,1,0,0,0));
        add("addi W",   OPC_OPIMM, 0, 1, wb(0,0));
        add("add F",    OPC_OP,    0, 1, fe());
        add("add D",    OPC_OP,    0, 1, de(0));
        add("add E",    OPC_OP,    0, 1, o(2,0,0,0,0,0,0,0,0,0,1,0,0,0));
        add("add W",    OPC_OP,    0, 1, wb(0,0));
        add("sw F",     OPC_STORE, 0, 1, fe());
        add("sw D",     OPC_STORE, 0, 1, de(1));
        add("sw E",     OPC_STORE, 0, 1, o(2,0,0,0,0,0,0,1,0,1,0,0,0,0));
        add("sw M w1",  OPC_STORE, 0, 0, o(3,1,1,1,0,0,0,1,0,0,0,0,0,0));
        add("sw M w2",  OPC_STORE, 0, 0, o(3,1,1,1,0,0,0,1,0,0,0,0,0,0));
        add("sw M",     OPC_STORE, 0, 1, o(3,1,1,1,0,0,0,1,0,0,0,0,0,0));
        add("beq F",    OPC_BRANCH, 1, 1, fe());
        add("beq D",    OPC_BRANCH, 1, 1, de(2));
        add("beq E tk", OPC_BRANCH, 1, 1, o(2,0,0,0,0,1,1,2,0,0,0,0,0,0));
        add("beq F2",   OPC_BRANCH, 0, 1, fe());
        add("beq D2",   OPC_BRANCH, 0, 1, de(2));
        add("beq E nt", OPC_BRANCH, 0, 1, o(2,0,0,0,0,0,1,2,0,0,0,0,0,0));
        add("jal F",    OPC_JAL,   0, 1, fe());
        add("jal D",    OPC_JAL,   0, 1, de(4));
        add("jal E",    OPC_JAL,   0, 1, o(2,0,0,0,0,1,1,4,0,0,0,0,0,0));
        add("jal W",    OPC_JAL,   0, 1, wb(4,2));
        add("jalr F",   OPC_JALR,  0, 1, fe());
        add("jalr D",   OPC_JALR,  0, 1, de(0));
        add("jalr E",   OPC_JALR,  0, 1, o(2,0,0,0,0,1,0,0,0,1,0,0,0,0));
        add("jalr W",   OPC_JALR,  0, 1, wb(0,2));
        add("auipc F",  OPC_AUIPC, 0, 1, fe());
        add("auipc D",  OPC_AUIPC, 0, 1, de(3));
        add("auipc E",  OPC_AUIPC, 0, 1, o(2,0,0,0,0,0,0,3,2,1,0,0,0,0));
        add("auipc W",  OPC_AUIPC, 0, 1, wb(3,0));
        add("lui F",    OPC_LUI,   0, 1, fe());
        add("lui D",    OPC_LUI,   0, 1, de(3));
        add("lui W",    OPC_LUI,   0, 1, wb(3,3));

        // Reset with memory ready high: everything must stay low.
        mif.mem_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        check("reset", o(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            opc = vecs[i].opc;
            tk  = vecs[i].tk;
            mif.mem_ready = vecs[i].rdy;
            #1;
            check(vecs[i].name, vecs[i].exp);
            @(negedge clk);
        end
        check_int("back in fetch", int'(st), 0);

        run_instr(OPC_LOAD, 0, 3, 2, cyc, irw_n, rgw_n, we_n, serr, wsel);
        check_int("lw wait cycles", cyc, 10);
        check_int("lw irwrite count", irw_n, 1);
        check_int("lw regwrite count", rgw_n, 1);
        check_int("lw wbsel", wsel, 1);
        check_int("lw no we", we_n, 0);

        run_instr(OPC_LOAD, 0, 0, 0, cyc, irw_n, rgw_n, we_n, serr, wsel);
        check_int("lw zero-wait cycles", cyc, 5);

        run_instr(OPC_STORE, 0, 0, 0, cyc, irw_n, rgw_n, we_n, serr, wsel);
        check_int("sw cycles", cyc, 4);
        check_int("sw no regwrite", rgw_n, 0);
        check_int("sw we cycles", we_n, 1);

        run_instr(OPC_STORE, 0, 1, 2, cyc, irw_n, rgw_n, we_n, serr, wsel);
        check_int("sw wait cycles", cyc, 7);
        check_int("sw we held", we_n, 3);
        check_int("sw strobe outside mem", serr, 0);

        run_instr(OPC_OPIMM, 0, 0, 0, cyc, irw_n, rgw_n, we_n, serr, wsel);
        check_int("addi cycles", cyc, 4);
        check_int("addi wbsel", wsel, 0);

        run_instr(OPC_BRANCH, 1, 0, 0, cyc, irw_n, rgw_n, we_n, serr, wsel);
        check_int("beq cycles", cyc, 3);

        run_instr(OPC_JAL, 0, 0, 0, cyc, irw_n, rgw_n, we_n, serr, wsel);
        check_int("jal cycles", cyc, 4);
        check_int("jal wbsel", wsel, 2);

        run_instr(OPC_LUI, 0, 0, 0, cyc, irw_n, rgw_n, we_n, serr, wsel);
        check_int("lui cycles", cyc, 3);
        check_int("lui wbsel", wsel, 3);

        // Illegal opcode: sticky trap, memory ready toggling is ignored.
        opc = 7'b1111111;
        mif.mem_ready = 1'b1;
        #1;
        @(negedge clk);
        #1;
        check_int("illegal decode state", int'(st), 1);
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            mif.mem_ready = 1'(k % 2);
            #1;
            check("trap", o(5,0,0,0,0,0,0,0,0,0,0,0,0,1));
            @(negedge clk);
        end

        rst_n = 1'b0;
        #3;
        check_int("trap cleared by reset", int'(ill), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a data load waits in MEM.
        opc = OPC_LOAD;
        mif.mem_ready = 1'b1;
        #1; @(negedge clk);
        #1; @(negedge clk);
        #1; @(negedge clk);
        mif.mem_ready = 1'b0;
        #1;
        check("mem wait", o(3,1,0,1,0,0,0,0,0,0,0,0,0,0));
        #2;
        rst_n = 1'b0;
        #1;
        check("reset mid mem", o(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(OPC_OPIMM, 0, 0, 0, cyc, irw_n, rgw_n, we_n, serr, wsel);
        check_int("restart addi cycles", cyc, 4);
        check_int("restart regwrite", rgw_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
